// File: rtl/id_decode_pipe_if.sv
// IF/ID -> ID/EX handshake and decoded control bundle for id_decode_pipe.
interface id_decode_pipe_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [PC_W-1:0]  if_pc;
  logic             flush;
  logic             id_ready;
  logic             ex_valid;
  logic [3:0]       ex_alu_op;
  logic             ex_alu_a_sel;
  logic             ex_alu_b_sel;
  logic [2:0]       ex_imm_sel;
  logic [1:0]       ex_result_sel;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_jalr;
  logic [2:0]       ex_funct3;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_illegal;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output if_valid, if_instr, if_pc, flush,
    input  id_ready, ex_valid, ex_alu_op, ex_alu_a_sel, ex_alu_b_sel, ex_imm_sel,
           ex_result_sel, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_jump, ex_jalr, ex_funct3, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_illegal,
           stall_count
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush,
    output id_ready, ex_valid, ex_alu_op, ex_alu_a_sel, ex_alu_b_sel, ex_imm_sel,
           ex_result_sel, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_jump, ex_jalr, ex_funct3, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_illegal,
           stall_count
  );
endinterface

// File: rtl/id_decode_pipe.sv
// RV32I decode stage: combinational decode into the ID/EX register, with
// load-use stall FSM, EX flush squash and a saturating stall-cycle counter.
module id_decode_pipe #(
  parameter int PC_W         = 32,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst,
  id_decode_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_CMP   = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_SLTU  = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_sel_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic {RUN, STALL} state_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        a_sel;
    logic        b_sel;
    imm_sel_e    imm_sel;
    result_sel_e result_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } id_ex_t;

  localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  ctrl_t      raw;
  ctrl_t      dec;
  logic       legal;
  logic       rs1_used;
  logic       rs2_used;
  logic       hazard;
  logic       id_ready;

  state_e     state;
  logic [2:0] cnt;
  id_ex_t     ex_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign opcode = bus.if_instr[6:0];
  assign rd     = bus.if_instr[11:7];
  assign funct3 = bus.if_instr[14:12];
  assign rs1    = bus.if_instr[19:15];
  assign rs2    = bus.if_instr[24:20];
  assign funct7 = bus.if_instr[31:25];

  // Shared R / I-ALU operation map; alt selects SUB/SRA.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Combinational decode; unrecognised encodings zero every control field.
  always_comb begin
    raw      = '0;
    legal    = 1'b0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5));
        raw.alu_op    = alu_from_funct(funct3, funct7[5]);
        raw.reg_write = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_IMM: begin
        if (funct3 == 3'd1)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'd5) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                     legal = 1'b1;
        raw.alu_op    = alu_from_funct(funct3, (funct3 == 3'd5) && funct7[5]);
        raw.b_sel     = 1'b1;
        raw.imm_sel   = IMM_I;
        raw.reg_write = 1'b1;
      end
      OP_LOAD: begin
        legal          = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        raw.alu_op     = ALU_ADD;
        raw.b_sel      = 1'b1;
        raw.imm_sel    = IMM_I;
        raw.result_sel = RES_MEM;
        raw.mem_read   = 1'b1;
        raw.reg_write  = 1'b1;
      end
      OP_STORE: begin
        legal         = funct3 inside {3'd0, 3'd1, 3'd2};
        raw.alu_op    = ALU_ADD;
        raw.b_sel     = 1'b1;
        raw.imm_sel   = IMM_S;
        raw.mem_write = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_BRANCH: begin
        legal       = !(funct3 inside {3'd2, 3'd3});
        raw.alu_op  = ALU_CMP;
        raw.imm_sel = IMM_B;
        raw.branch  = 1'b1;
        rs2_used    = 1'b1;
      end
      OP_JAL: begin
        legal          = 1'b1;
        raw.imm_sel    = IMM_J;
        raw.result_sel = RES_PC4;
        raw.jump       = 1'b1;
        raw.reg_write  = 1'b1;
        rs1_used       = 1'b0;
      end
      OP_JALR: begin
        legal          = (funct3 == 3'd0);
        raw.alu_op     = ALU_ADD;
        raw.b_sel      = 1'b1;
        raw.imm_sel    = IMM_I;
        raw.result_sel = RES_PC4;
        raw.jalr       = 1'b1;
        raw.reg_write  = 1'b1;
      end
      OP_LUI: begin
        legal         = 1'b1;
        raw.alu_op    = ALU_PASSB;
        raw.b_sel     = 1'b1;
        raw.imm_sel   = IMM_U;
        raw.reg_write = 1'b1;
        rs1_used      = 1'b0;
      end
      OP_AUIPC: begin
        legal         = 1'b1;
        raw.alu_op    = ALU_ADD;
        raw.a_sel     = 1'b1;
        raw.b_sel     = 1'b1;
        raw.imm_sel   = IMM_U;
        raw.reg_write = 1'b1;
        rs1_used      = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    dec = legal ? raw : '0;
  end

  // Load-use hazard against the load currently sitting in ID/EX.
  always_comb begin
    hazard = bus.if_valid & ex_q.valid & ex_q.ctrl.mem_read & (ex_q.rd != 5'd0) &
             ((rs1_used & (rs1 == ex_q.rd)) | (rs2_used & (rs2 == ex_q.rd)));
  end

  // Accept unless stalling; flush always frees the front end.
  always_comb begin
    if (bus.flush)            id_ready = 1'b1;
    else if (state == STALL)  id_ready = 1'b0;
    else if (!bus.if_valid)   id_ready = 1'b1;
    else                      id_ready = !hazard;
  end

  // Stall FSM and ID/EX register; every non-issue path writes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      ex_q  <= '0;
    end else if (bus.flush) begin
      state <= RUN;
      cnt   <= '0;
      ex_q  <= '0;
    end else if (state == STALL) begin
      ex_q <= '0;
      cnt  <= cnt - 3'd1;
      if (cnt == 3'd1) state <= RUN;
    end else if (!bus.if_valid) begin
      ex_q <= '0;
    end else if (hazard) begin
      ex_q  <= '0;
      cnt   <= STALL_LOAD;
      state <= (STALL_LOAD == 3'd0) ? RUN : STALL;
    end else begin
      ex_q.valid   <= 1'b1;
      ex_q.ctrl    <= dec;
      ex_q.funct3  <= funct3;
      ex_q.rs1     <= rs1;
      ex_q.rs2     <= rs2;
      ex_q.rd      <= rd;
      ex_q.pc      <= bus.if_pc;
      ex_q.illegal <= !legal;
    end
  end

  // Saturating count of cycles spent with decode held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!id_ready && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.id_ready      = id_ready;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_alu_op     = ex_q.ctrl.alu_op;
  assign bus.ex_alu_a_sel  = ex_q.ctrl.a_sel;
  assign bus.ex_alu_b_sel  = ex_q.ctrl.b_sel;
  assign bus.ex_imm_sel    = ex_q.ctrl.imm_sel;
  assign bus.ex_result_sel = ex_q.ctrl.result_sel;
  assign bus.ex_reg_write  = ex_q.ctrl.reg_write;
  assign bus.ex_mem_read   = ex_q.ctrl.mem_read;
  assign bus.ex_mem_write  = ex_q.ctrl.mem_write;
  assign bus.ex_branch     = ex_q.ctrl.branch;
  assign bus.ex_jump       = ex_q.ctrl.jump;
  assign bus.ex_jalr       = ex_q.ctrl.jalr;
  assign bus.ex_funct3     = ex_q.funct3;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_illegal    = ex_q.illegal;
  assign bus.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Bench for id_decode_pipe: two instances (1 and 3 stall cycles, the latter
// with a 4-bit stall counter) driven in lockstep and compared to a reference.
module tb_id_decode_pipe;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic        a_sel;
    logic        b_sel;
    logic [2:0]  imm_sel;
    logic [1:0]  result_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        illegal;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;

  always #5 clk = ~clk;

  id_decode_pipe_if #(.PC_W(32), .CNT_W(16)) bus1 ();
  id_decode_pipe_if #(.PC_W(32), .CNT_W(4))  bus3 ();

  assign bus1.if_valid = valid;
  assign bus1.if_instr = instr;
  assign bus1.if_pc    = pc;
  assign bus1.flush    = flush;
  assign bus3.if_valid = valid;
  assign bus3.if_instr = instr;
  assign bus3.if_pc    = pc;
  assign bus3.flush    = flush;

  id_decode_pipe #(.PC_W(32), .STALL_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  id_decode_pipe #(.PC_W(32), .STALL_CYCLES(3), .CNT_W(4))  dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  ex_t         d_ex [2];
  logic        d_rdy [2];
  logic [15:0] d_sc [2];

  always_comb begin
    d_ex[0] = {bus1.ex_valid, bus1.ex_alu_op, bus1.ex_alu_a_sel, bus1.ex_alu_b_sel, bus1.ex_imm_sel,
               bus1.ex_result_sel, bus1.ex_reg_write, bus1.ex_mem_read, bus1.ex_mem_write,
               bus1.ex_branch, bus1.ex_jump, bus1.ex_jalr, bus1.ex_funct3, bus1.ex_rs1,
               bus1.ex_rs2, bus1.ex_rd, bus1.ex_pc, bus1.ex_illegal};
    d_ex[1] = {bus3.ex_valid, bus3.ex_alu_op, bus3.ex_alu_a_sel, bus3.ex_alu_b_sel, bus3.ex_imm_sel,
               bus3.ex_result_sel, bus3.ex_reg_write, bus3.ex_mem_read, bus3.ex_mem_write,
               bus3.ex_branch, bus3.ex_jump, bus3.ex_jalr, bus3.ex_funct3, bus3.ex_rs1,
               bus3.ex_rs2, bus3.ex_rd, bus3.ex_pc, bus3.ex_illegal};
    d_rdy[0] = bus1.id_ready;
    d_rdy[1] = bus3.id_ready;
    d_sc[0]  = bus1.stall_count;
    d_sc[1]  = {12'b0, bus3.stall_count};
  end

  // Reference state: expected ID/EX contents, stall cycles still owed, stall count.
  ex_t m_ex [2];
  int  m_left [2];
  int  m_scnt [2];
  int  stall_of [2] = '{1, 3};
  int  cnt_max [2]  = '{65535, 15};
  logic last_rdy [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
    ex_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd7, 4'd4, 4'd10, 4'd6, 4'd8, 4'd3, 4'd2};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e = '0;
    e.valid = 1'b1; e.funct3 = f3; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.pc = p;
    ok = 1'b1;
    case (op)
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu_op = tab[f3] + {3'b0, f7[5]}; e.reg_write = 1'b1;
      end
      7'h13: begin
        ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        e.alu_op = tab[f3] + {3'b0, (f3 == 3'd5) && f7[5]}; e.b_sel = 1'b1; e.reg_write = 1'b1;
      end
      7'h03: begin
        ok = (f3 != 3'd3 && f3 < 3'd6);
        e.b_sel = 1'b1; e.result_sel = 2'd1; e.mem_read = 1'b1; e.reg_write = 1'b1;
      end
      7'h23: begin ok = (f3 < 3'd3); e.b_sel = 1'b1; e.imm_sel = 3'd1; e.mem_write = 1'b1; end
      7'h63: begin ok = (f3 != 3'd2 && f3 != 3'd3); e.alu_op = 4'd5; e.imm_sel = 3'd2; e.branch = 1'b1; end
      7'h6F: begin e.imm_sel = 3'd3; e.result_sel = 2'd2; e.jump = 1'b1; e.reg_write = 1'b1; end
      7'h67: begin
        ok = (f3 == 3'd0);
        e.b_sel = 1'b1; e.result_sel = 2'd2; e.jalr = 1'b1; e.reg_write = 1'b1;
      end
      7'h37: begin e.alu_op = 4'd11; e.b_sel = 1'b1; e.imm_sel = 3'd4; e.reg_write = 1'b1; end
      7'h17: begin e.a_sel = 1'b1; e.b_sel = 1'b1; e.imm_sel = 3'd4; e.reg_write = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.alu_op = '0; e.a_sel = 1'b0; e.b_sel = 1'b0; e.imm_sel = '0; e.result_sel = '0;
      e.reg_write = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0;
      e.branch = 1'b0; e.jump = 1'b0; e.jalr = 1'b0; e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic bit ref_hazard(input int k);
    logic [6:0] op;
    bit u1, u2;
    op = instr[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return valid && m_ex[k].valid && m_ex[k].mem_read && (m_ex[k].rd != 5'd0) &&
           ((u1 && instr[19:15] == m_ex[k].rd) || (u2 && instr[24:20] == m_ex[k].rd));
  endfunction

  function automatic bit ref_ready(input int k);
    if (flush) return 1'b1;
    if (m_left[k] > 0) return 1'b0;
    if (!valid) return 1'b1;
    return !ref_hazard(k);
  endfunction

  task automatic model_step(input int k, input bit rdy);
    bit h;
    h = ref_hazard(k);
    if (!rdy && m_scnt[k] < cnt_max[k]) m_scnt[k]++;
    if (flush) begin
      m_left[k] = 0; m_ex[k] = '0;
    end else if (m_left[k] > 0) begin
      m_left[k]--; m_ex[k] = '0;
    end else if (!valid) begin
      m_ex[k] = '0;
    end else if (h) begin
      m_left[k] = stall_of[k] - 1; m_ex[k] = '0;
    end else begin
      m_ex[k] = ref_decode(instr, pc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_left[k] = 0; m_scnt[k] = 0;
    end
  endtask

  // One clock: inputs already set at the falling edge.
  task automatic cycle();
    bit er [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      er[k] = ref_ready(k);
      chk($sformatf("id_ready[%0d]", k), d_rdy[k], er[k]);
      last_rdy[k] = d_rdy[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, er[k]);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ex[%0d]", k), d_ex[k], m_ex[k]);
      chk($sformatf("stall_count[%0d]", k), d_sc[k], m_scnt[k]);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ex[%0d]", tag, k), d_ex[k], 0);
      chk($sformatf("%s_ready[%0d]", tag, k), d_rdy[k], 1);
      chk($sformatf("%s_sc[%0d]", tag, k), d_sc[k], 0);
    end
  endtask

  initial begin
    int low [2];
    logic [31:0] ops [11];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] r1, r2, rdd;
    ops = '{32'h33, 32'h13, 32'h03, 32'h03, 32'h23, 32'h63, 32'h6F, 32'h67, 32'h37, 32'h17, 32'h03};

    rst = 1'b0; valid = 1'b0; flush = 1'b0; instr = '0; pc = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state("reset");
    model_reset();
    rst = 1'b0;
    @(negedge clk);

    // add x3,x1,x2
    valid = 1'b1; instr = 32'h002081B3; pc = 32'h100;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("add_ready", last_rdy[k], 1);
      chk("add_alu_op", d_ex[k].alu_op, 0);
      chk("add_rs1", d_ex[k].rs1, 1);
      chk("add_rs2", d_ex[k].rs2, 2);
      chk("add_rd", d_ex[k].rd, 3);
      chk("add_reg_write", d_ex[k].reg_write, 1);
      chk("add_valid", d_ex[k].valid, 1);
    end

    // lw x5,0(x1) then dependent add x6,x5,x0 held for four cycles
    instr = 32'h0000A283; pc = 32'h104;
    cycle();
    instr = 32'h00028333; pc = 32'h108;
    low = '{0, 0};
    repeat (4) begin
      cycle();
      for (int k = 0; k < 2; k++) if (!last_rdy[k]) low[k]++;
    end
    chk("lu_low_cycles[0]", low[0], 1);
    chk("lu_low_cycles[1]", low[1], 3);
    chk("lu_stall_count[0]", d_sc[0], 1);
    chk("lu_stall_count[1]", d_sc[1], 3);
    for (int k = 0; k < 2; k++) begin
      chk("lu_add_valid", d_ex[k].valid, 1);
      chk("lu_add_rd", d_ex[k].rd, 6);
    end

    // Same hazard, flush on the second stall cycle of the 3-cycle instance
    instr = 32'h0000A283; pc = 32'h10C;
    cycle();
    instr = 32'h00028333; pc = 32'h110;
    cycle();
    chk("fl_hazard_ready", last_rdy[1], 0);
    flush = 1'b1;
    cycle();
    chk("fl_ready", last_rdy[1], 1);
    chk("fl_bubble", d_ex[1].valid, 0);
    flush = 1'b0;
    cycle();
    chk("fl_run_ready", last_rdy[1], 1);
    chk("fl_run_rd", d_ex[1].rd, 6);

    // lw x5 then lui x7 (no source registers): no stall
    instr = 32'h0000A283; pc = 32'h200;
    cycle();
    instr = 32'h123453B7; pc = 32'h204;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("lui_ready", last_rdy[k], 1);
      chk("lui_alu_op", d_ex[k].alu_op, 11);
      chk("lui_imm_sel", d_ex[k].imm_sel, 4);
      chk("lui_rd", d_ex[k].rd, 7);
    end

    // jal x1,8
    instr = 32'h008000EF; pc = 32'h208;
    cycle();
    chk("jal_jump", d_ex[0].jump, 1);
    chk("jal_imm_sel", d_ex[0].imm_sel, 3);
    chk("jal_result_sel", d_ex[0].result_sel, 2);
    chk("jal_rd", d_ex[0].rd, 1);

    // all-ones word is illegal
    instr = 32'hFFFFFFFF; pc = 32'h20C;
    cycle();
    chk("ill_flag", d_ex[0].illegal, 1);
    chk("ill_enables", {d_ex[0].reg_write, d_ex[0].mem_read, d_ex[0].mem_write,
                        d_ex[0].branch, d_ex[0].jump, d_ex[0].jalr}, 0);

    // Randomised traffic; an instruction is held while the 3-cycle instance stalls
    for (int i = 0; i < 800; i++) begin
      if (last_rdy[1] || !valid) begin
        op  = ops[$urandom_range(0, 10)][6:0];
        if ($urandom_range(0, 15) == 0) op = 7'($urandom);
        f3  = 3'($urandom);
        f7  = ($urandom_range(0, 3) == 0) ? 7'h20 : (($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00);
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        rdd = 5'($urandom_range(0, 3));
        instr = {f7, r2, r1, f3, rdd, op};
        pc    = $urandom;
      end
      valid = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a 3-cycle stall
    valid = 1'b1; instr = 32'h0000A283; pc = 32'h300;
    cycle();
    instr = 32'h00028333; pc = 32'h304;
    cycle();
    chk("mr_stalling", last_rdy[1], 0);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("mr_resume_ready", last_rdy[1], 1);
    chk("mr_resume_rd", d_ex[1].rd, 6);
    chk("mr_resume_sc", d_sc[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
